// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for the memory arbiter (package mem_arbiter_wires)
package mem_arbiter_wires;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_type;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;

    typedef struct packed {
        logic        valid;
        logic        fence;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } pend_type;

    localparam pend_type init_pend = '0;

    function automatic pend_type to_pend(input mem_in_type m);
        return '{valid: m.mem_valid, fence: m.mem_fence, instr: m.mem_instr,
                 addr: m.mem_addr, wdata: m.mem_wdata, wstrb: m.mem_wstrb};
    endfunction

    function automatic mem_in_type to_mem(input pend_type p);
        return '{mem_valid: p.valid, mem_fence: p.fence, mem_instr: p.instr,
                 mem_addr: p.addr, mem_wdata: p.wdata, mem_wstrb: p.wstrb};
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one memory port (request + response) with master/slave views
interface mem_arbiter_if;
    mem_arbiter_wires::mem_in_type  mem_in;
    mem_arbiter_wires::mem_out_type mem_out;
    modport master (output mem_in, input mem_out);
    modport slave  (input mem_in, output mem_out);
endinterface

// File: rtl/mem_arbiter_pend.sv
// mem_arbiter_pend: per-master capture register holding the request until it completes
module mem_arbiter_pend
    import mem_arbiter_wires::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       clr,
    input  mem_in_type d,
    output pend_type   q
);

    // a new capture wins over the clear of the request just completed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= init_pend;
        else if (req) q <= to_pend(d);
        else if (clr) q <= init_pend;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: merges instruction and data TIM memory ports onto one external port; MEM_ARBITER_RR_EN selects round-robin
module mem_arbiter
    import mem_arbiter_wires::*;
#(
    parameter logic dprio = 1'b1
) (
    input  logic          rst,
    input  logic          clk,
    mem_arbiter_if.slave  imem,
    mem_arbiter_if.slave  dmem,
    mem_arbiter_if.master mem
);

    state_type  state, state_nx;
    pend_type   pend_i, pend_d;
    mem_in_type src_i, src_d, mem_q, mem_nx;
    logic done_i, done_d, live_i, live_d, req_i, req_d, cand_i, cand_d, issue, pick_d;

    assign done_i = (state == BUSY_I) & mem.mem_out.mem_ready;
    assign done_d = (state == BUSY_D) & mem.mem_out.mem_ready;
    // a capture is still outstanding unless it is the one completing this cycle
    assign live_i = pend_i.valid & ~done_i;
    assign live_d = pend_d.valid & ~done_d;
    // the owner's valid in its ready cycle is already the next request
    assign req_i  = imem.mem_in.mem_valid & (~pend_i.valid | done_i);
    assign req_d  = dmem.mem_in.mem_valid & (~pend_d.valid | done_d);
    assign cand_i = live_i | req_i;
    assign cand_d = live_d | req_d;
    assign src_i  = live_i ? to_mem(pend_i) : imem.mem_in;
    assign src_d  = live_d ? to_mem(pend_d) : dmem.mem_in;
    assign issue  = ((state == IDLE) | done_i | done_d) & (cand_i | cand_d);

`ifdef MEM_ARBITER_RR_EN
    logic rr, last_d;
    assign last_d = done_d | (~done_i & rr);
    assign pick_d = cand_d & (~cand_i | ~last_d);
    // remember which port was served last so a tie goes to the other one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rr <= 1'b0;
        else if (done_i | done_d) rr <= done_d;
    end
`else
    assign pick_d = cand_d & (~cand_i | dprio);
`endif

    mem_arbiter_pend u_pend_i (.clk(clk), .rst(rst), .req(req_i), .clr(done_i), .d(imem.mem_in), .q(pend_i));
    mem_arbiter_pend u_pend_d (.clk(clk), .rst(rst), .req(req_d), .clr(done_d), .d(dmem.mem_in), .q(pend_d));

    // grant decision; the issued request pulses valid for one cycle and holds its fields
    always_comb begin
        state_nx = state;
        mem_nx = mem_q;
        mem_nx.mem_valid = 1'b0;
        if (issue) begin
            state_nx = pick_d ? BUSY_D : BUSY_I;
            mem_nx = pick_d ? src_d : src_i;
            mem_nx.mem_valid = 1'b1;
        end else if (done_i | done_d) begin
            state_nx = IDLE;
        end
    end

    // state and external request register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            mem_q <= '0;
        end else begin
            state <= state_nx;
            mem_q <= mem_nx;
        end
    end

    assign mem.mem_in = mem_q;
    assign imem.mem_out = '{mem_ready: done_i, mem_rdata: done_i ? mem.mem_out.mem_rdata : 32'h0};
    assign dmem.mem_out = '{mem_ready: done_d, mem_rdata: done_d ? mem.mem_out.mem_rdata : 32'h0};

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import mem_arbiter_wires::*;

    logic clk, rst;
    int n_cmp = 0;
    int n_err = 0;
    bit i_first;

    mem_arbiter_if ib ();
    mem_arbiter_if db ();
    mem_arbiter_if mb ();

    mem_arbiter #(.dprio(1'b1)) dut (.rst(rst), .clk(clk), .imem(ib), .dmem(db), .mem(mb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic slv(input logic rdy, input logic [31:0] d);
        mb.mem_out = '{mem_ready: rdy, mem_rdata: d};
    endtask

    function automatic mem_in_type rd(input logic [31:0] a, input logic ins);
        return '{mem_valid: 1'b1, mem_fence: 1'b0, mem_instr: ins, mem_addr: a, mem_wdata: 32'h0, mem_wstrb: 4'h0};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
`ifdef MEM_ARBITER_RR_EN
        i_first = 1'b1;
`else
        i_first = 1'b0;
`endif
        rst = 1'b0;
        ib.mem_in = '0;
        db.mem_in = '0;
        slv(1'b0, 32'h0);
        #12;
        chk("rst_mem_in", 72'(mb.mem_in), 72'h0);
        chk("rst_imem_out", 72'(ib.mem_out), 72'h0);
        chk("rst_dmem_out", 72'(db.mem_out), 72'h0);
        rst = 1'b1;
        tick();

        // single read
        db.mem_in = rd(32'h8000_0010, 1'b0);
        #1 chk("rd_no_early_ready", 72'(db.mem_out.mem_ready), 72'h0);
        tick();
        chk("rd_issue_valid", 72'(mb.mem_in.mem_valid), 72'h1);
        chk("rd_issue_addr", 72'(mb.mem_in.mem_addr), 72'h8000_0010);
        chk("rd_issue_wstrb", 72'(mb.mem_in.mem_wstrb), 72'h0);
        tick();
        chk("rd_valid_pulse", 72'(mb.mem_in.mem_valid), 72'h0);
        chk("rd_addr_held", 72'(mb.mem_in.mem_addr), 72'h8000_0010);
        tick();
        slv(1'b1, 32'hDEAD_BEEF);
        db.mem_in = '0;
        #1;
        chk("rd_dready", 72'(db.mem_out.mem_ready), 72'h1);
        chk("rd_drdata", 72'(db.mem_out.mem_rdata), 72'hDEAD_BEEF);
        chk("rd_iready", 72'(ib.mem_out.mem_ready), 72'h0);
        chk("rd_irdata", 72'(ib.mem_out.mem_rdata), 72'h0);
        tick();
        slv(1'b0, 32'h0);
        chk("rd_idle_valid", 72'(mb.mem_in.mem_valid), 72'h0);
        slv(1'b1, 32'h1234);
        #1;
        chk("stale_dready", 72'(db.mem_out.mem_ready), 72'h0);
        chk("stale_drdata", 72'(db.mem_out.mem_rdata), 72'h0);
        chk("stale_iready", 72'(ib.mem_out.mem_ready), 72'h0);
        tick();
        slv(1'b0, 32'h0);
        chk("stale_no_issue", 72'(mb.mem_in.mem_valid), 72'h0);

        // 4-beat data burst with a 1-cycle slave
        db.mem_in = rd(32'h100, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            slv(1'b0, 32'h0);
            chk($sformatf("burst%0d_valid", k), 72'(mb.mem_in.mem_valid), 72'h1);
            chk($sformatf("burst%0d_addr", k), 72'(mb.mem_in.mem_addr), 72'(32'h100 + 32'(4 * k)));
            tick();
            chk($sformatf("burst%0d_gap", k), 72'(mb.mem_in.mem_valid), 72'h0);
            slv(1'b1, 32'hB0 + 32'(k));
            db.mem_in = (k < 3) ? rd(32'h104 + 32'(4 * k), 1'b0) : '0;
            #1;
            chk($sformatf("burst%0d_ready", k), 72'(db.mem_out.mem_ready), 72'h1);
            chk($sformatf("burst%0d_rdata", k), 72'(db.mem_out.mem_rdata), 72'(32'hB0 + 32'(k)));
        end
        tick();
        slv(1'b0, 32'h0);
        chk("burst_no_extra", 72'(mb.mem_in.mem_valid), 72'h0);
        tick();
        chk("burst_idle", 72'(mb.mem_in.mem_valid), 72'h0);

        // collision: both masters request in the same cycle
        ib.mem_in = rd(32'h200, 1'b1);
        db.mem_in = rd(32'h300, 1'b0);
        tick();
        chk("col1_valid", 72'(mb.mem_in.mem_valid), 72'h1);
        chk("col1_addr", 72'(mb.mem_in.mem_addr), i_first ? 72'h200 : 72'h300);
        chk("col1_instr", 72'(mb.mem_in.mem_instr), 72'(i_first));
        tick();
        slv(1'b1, 32'h33);
        if (i_first) ib.mem_in = '0;
        else db.mem_in = '0;
        #1;
        chk("col1_iready", 72'(ib.mem_out.mem_ready), 72'(i_first));
        chk("col1_dready", 72'(db.mem_out.mem_ready), 72'(!i_first));
        tick();
        slv(1'b0, 32'h0);
        chk("col2_valid", 72'(mb.mem_in.mem_valid), 72'h1);
        chk("col2_addr", 72'(mb.mem_in.mem_addr), i_first ? 72'h300 : 72'h200);
        chk("col2_instr", 72'(mb.mem_in.mem_instr), 72'(!i_first));
        tick();
        slv(1'b1, 32'h22);
        ib.mem_in = '0;
        db.mem_in = '0;
        #1;
        chk("col2_iready", 72'(ib.mem_out.mem_ready), 72'(!i_first));
        chk("col2_dready", 72'(db.mem_out.mem_ready), 72'(i_first));
        chk("col2_rdata", 72'(i_first ? db.mem_out.mem_rdata : ib.mem_out.mem_rdata), 72'h22);
        tick();
        slv(1'b0, 32'h0);
        chk("col_idle", 72'(mb.mem_in.mem_valid), 72'h0);

        // write with byte strobes and fence forwarded
        db.mem_in = '{mem_valid: 1'b1, mem_fence: 1'b1, mem_instr: 1'b0, mem_addr: 32'h400,
                      mem_wdata: 32'h0000_A5A5, mem_wstrb: 4'h3};
        tick();
        chk("wr_valid", 72'(mb.mem_in.mem_valid), 72'h1);
        chk("wr_wstrb", 72'(mb.mem_in.mem_wstrb), 72'h3);
        chk("wr_wdata", 72'(mb.mem_in.mem_wdata), 72'h0000_A5A5);
        chk("wr_fence", 72'(mb.mem_in.mem_fence), 72'h1);
        tick();
        tick();
        chk("wr_held_wstrb", 72'(mb.mem_in.mem_wstrb), 72'h3);
        chk("wr_held_wdata", 72'(mb.mem_in.mem_wdata), 72'h0000_A5A5);
        chk("wr_held_addr", 72'(mb.mem_in.mem_addr), 72'h400);
        slv(1'b1, 32'h0);
        db.mem_in = '0;
        #1 chk("wr_ready", 72'(db.mem_out.mem_ready), 72'h1);
        tick();
        slv(1'b0, 32'h0);

`ifdef MEM_ARBITER_RR_EN
        // starvation: instruction request arrives during a data burst
        db.mem_in = rd(32'h600, 1'b0);
        tick();
        chk("starve_d0_addr", 72'(mb.mem_in.mem_addr), 72'h600);
        ib.mem_in = rd(32'h700, 1'b1);
        tick();
        slv(1'b1, 32'h60);
        db.mem_in = rd(32'h604, 1'b0);
        #1 chk("starve_d0_ready", 72'(db.mem_out.mem_ready), 72'h1);
        tick();
        slv(1'b0, 32'h0);
        chk("starve_i_valid", 72'(mb.mem_in.mem_valid), 72'h1);
        chk("starve_i_addr", 72'(mb.mem_in.mem_addr), 72'h700);
        tick();
        slv(1'b1, 32'h70);
        ib.mem_in = '0;
        #1 chk("starve_i_ready", 72'(ib.mem_out.mem_ready), 72'h1);
        tick();
        slv(1'b0, 32'h0);
        chk("starve_d1_addr", 72'(mb.mem_in.mem_addr), 72'h604);
        tick();
        slv(1'b1, 32'h64);
        db.mem_in = '0;
        #1 chk("starve_d1_ready", 72'(db.mem_out.mem_ready), 72'h1);
        tick();
        slv(1'b0, 32'h0);
`endif

        // reset in the middle of a data transaction
        db.mem_in = rd(32'h500, 1'b0);
        tick();
        chk("rstm_issue", 72'(mb.mem_in.mem_valid), 72'h1);
        rst = 1'b0;
        #1;
        chk("rstm_mem_in", 72'(mb.mem_in), 72'h0);
        db.mem_in = '0;
        slv(1'b1, 32'h55);
        #1;
        chk("rstm_dready", 72'(db.mem_out.mem_ready), 72'h0);
        tick();
        rst = 1'b1;
        tick();
        chk("rstm_stale_dready", 72'(db.mem_out.mem_ready), 72'h0);
        slv(1'b0, 32'h0);
        tick();
        chk("rstm_mem_in_after", 72'(mb.mem_in), 72'h0);
        chk("rstm_dmem_out_after", 72'(db.mem_out), 72'h0);
        chk("rstm_imem_out_after", 72'(ib.mem_out), 72'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
